// File: rtl/seq_mul_radix_pkg.sv
// rtl/seq_mul_radix_pkg.sv - shared types and sizing helpers for the radix-2^R sequential multiplier
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cycles(input int n, input int r);
    return n / r;
  endfunction

  // One guard bit above N+R keeps the sum of accumulator and partial product exact
  function automatic int acc_width(input int n, input int r);
    return n + r + 1;
  endfunction

endpackage

// File: rtl/seq_mul_radix_digit_pp.sv
// rtl/seq_mul_radix_digit_pp.sv - R-bit digit times N-bit multiplicand partial product
module mul_digit_pp
  import mul_pkg::*;
#(
  parameter int N = 8,
  parameter int R = 2
) (
  input  logic [N-1:0]        a,
  input  logic [R-1:0]        d,
  input  logic                signed_mode,
  input  logic                last_digit,
  output logic signed [N+R:0] pp
);

  localparam int W = acc_width(N, R);

  logic signed [W-1:0] a_ext;
  logic signed [W-1:0] d_ext;

  // Only the most significant digit of a signed multiplier carries negative weight
  assign a_ext = {{(R + 1){signed_mode & a[N-1]}}, a};
  assign d_ext = {{(W - R){signed_mode & last_digit & d[R-1]}}, d};
  assign pp    = a_ext * d_ext;

endmodule

// File: rtl/seq_mul_radix.sv
// rtl/seq_mul_radix.sv - handshaked right-shift multiplier retiring R multiplier bits per clock
module seq_mul_radix
  import mul_pkg::*;
#(
  parameter int N = 8,
  parameter int R = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   x,
  input  logic           signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] result,
  output logic           busy
);

  localparam int CYC = cycles(N, R);
  localparam int W   = acc_width(N, R);
  localparam int CW  = $clog2(CYC + 1);

  if (N < 2 || R < 1 || R > N || (N % R) != 0) begin : g_bad_params
    $error("seq_mul_radix: N must be >= 2 and R must divide N with 1 <= R <= N");
  end

  state_t              state;
  logic [N-1:0]        a_reg;
  logic [N-1:0]        x_reg;
  logic [N-1:0]        lo;
  logic                sm_reg;
  logic [CW-1:0]       cnt;
  logic signed [W-1:0] acc;
  logic signed [W-1:0] pp;
  logic signed [W-1:0] acc_sum;
  logic [N+R-1:0]      lo_cat;
  logic                last;
  logic                accept;

  assign last     = (cnt == CW'(CYC - 1));
  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;

  mul_digit_pp #(.N(N), .R(R)) u_pp (
    .a          (a_reg),
    .d          (x_reg[R-1:0]),
    .signed_mode(sm_reg),
    .last_digit (last),
    .pp         (pp)
  );

  // Bits leaving the bottom of the accumulator feed the low product half from the top
  assign acc_sum = acc + pp;
  assign lo_cat  = {acc_sum[R-1:0], lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      x_reg  <= '0;
      lo     <= '0;
      sm_reg <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            a_reg  <= a;
            x_reg  <= x;
            sm_reg <= signed_mode;
            acc    <= '0;
            lo     <= '0;
            cnt    <= '0;
            state  <= RUN;
          end else if (state == DONE && out_ready) begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_sum >>> R;
          lo    <= lo_cat[N+R-1:R];
          x_reg <= x_reg >> R;
          cnt   <= cnt + CW'(1);
          if (last) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = {acc[N-1:0], lo};

endmodule

// File: tb/tb_seq_mul_radix.sv
// tb/tb_seq_mul_radix.sv - scoreboard bench: directed N=8,R=2 vectors plus random sweeps over (N,R)
module tb_seq_mul_radix;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  x;
  logic        sm;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0, t1, t2, t3, tm;

  logic [15:0] pend;
  logic [15:0] exp_q[$];
  int          acc_q[$];
  logic        prev_ov = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mul_radix #(.N(8), .R(2)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .x          (x),
    .signed_mode(sm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: acceptance pushes expectations, output handshakes pop and compare
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
        else begin
          tm = acc_q.pop_front();
          chk("latency", cyc - tm, 32'd4);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
        else chk("result", {16'd0, result}, {16'd0, exp_q.pop_front()});
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(pend);
        acc_q.push_back(cyc + 1);
      end
    end
    prev_ov <= out_valid;
  end

  task automatic issue(input logic [7:0] ta, input logic [7:0] tx, input logic ts,
                       input logic [15:0] te, output int tacc);
    bit ok;
    ok       = 1'b0;
    a        = ta;
    x        = tx;
    sm       = ts;
    pend     = te;
    in_valid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    tacc     = cyc;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; x = '0; sm = 1'b0; out_ready = 1'b1; pend = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_result", {16'd0, result}, 32'd0);
    @(posedge clk); #1;

    issue(8'h80, 8'h80, 1'b1, 16'h4000, t0); drain();
    issue(8'h7F, 8'h80, 1'b1, 16'hC080, t0); drain();
    issue(8'hFF, 8'h01, 1'b1, 16'hFFFF, t0); drain();
    issue(8'hFF, 8'hFF, 1'b0, 16'hFE01, t0); drain();
    issue(8'hFF, 8'hFF, 1'b1, 16'h0001, t0); drain();

    // Backpressure: hold the result for five cycles with the next operands waiting
    out_ready = 1'b0;
    issue(8'd100, 8'd3, 1'b1, 16'h012C, t0);
    a = 8'h80; x = 8'h02; sm = 1'b0; pend = 16'h0100; in_valid = 1'b1;
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", {16'd0, result}, 32'h012C);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    t0 = cyc;
    out_ready = 1'b1;
    issue(8'h80, 8'h02, 1'b0, 16'h0100, t1);
    chk("bp_accept_same_cycle", t1 - t0, 32'd1);
    drain();

    // Continuous input: one result per N/R+1 clocks
    issue(8'd7, 8'd9, 1'b1, 16'h003F, t1);
    @(negedge clk);
    chk("run_busy", {31'd0, busy}, 32'd1);
    chk("run_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    issue(8'hF9, 8'd9, 1'b1, 16'hFFC1, t2);
    issue(8'd200, 8'd200, 1'b0, 16'h9C40, t3);
    chk("throughput_1", t2 - t1, 32'd5);
    chk("throughput_2", t3 - t2, 32'd5);
    drain();

    // Reset during the second RUN cycle drops the operation
    issue(8'd50, 8'd50, 1'b0, 16'd2500, t0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_result", {16'd0, result}, 32'd0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("abort_no_out_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    issue(8'd3, 8'hFB, 1'b1, 16'hFFF1, t0);
    drain();

    for (int n = 0; n < 40000 && !(g_sweep[0].s_done && g_sweep[1].s_done &&
                                     g_sweep[2].s_done && g_sweep[3].s_done); n++)
      @(posedge clk);
    chk("sweep_done", {31'd0, g_sweep[0].s_done && g_sweep[1].s_done &&
                              g_sweep[2].s_done && g_sweep[3].s_done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Random sweeps against the behavioural product for other (N,R) points
  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int NN = (g == 3) ? 16 : 8;
    localparam int RR = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 4;

    logic              s_rst_n;
    logic              s_iv;
    logic              s_ir;
    logic              s_sm;
    logic              s_ov;
    logic              s_busy;
    logic              s_done = 1'b0;
    logic [NN-1:0]     s_a;
    logic [NN-1:0]     s_x;
    logic [2*NN-1:0]   s_res;
    logic [2*NN-1:0]   s_pend;
    logic [2*NN-1:0]   s_q[$];
    int                s_t[$];
    int                s_tm;

    seq_mul_radix #(.N(NN), .R(RR)) u_dut (
      .clk        (clk),
      .rst_n      (s_rst_n),
      .in_valid   (s_iv),
      .in_ready   (s_ir),
      .a          (s_a),
      .x          (s_x),
      .signed_mode(s_sm),
      .out_valid  (s_ov),
      .out_ready  (1'b1),
      .result     (s_res),
      .busy       (s_busy)
    );

    always @(negedge clk) begin
      if (s_rst_n) begin
        if (s_ov) begin
          if (s_q.size() == 0) chk("sweep_unexpected", 32'd1, 32'd0);
          else begin
            s_tm = s_t.pop_front();
            chk("sweep_result", 32'(s_res), 32'(s_q.pop_front()));
            chk("sweep_cycles", cyc - s_tm, 32'(NN / RR));
          end
        end
        if (s_iv && s_ir) begin
          s_q.push_back(s_pend);
          s_t.push_back(cyc + 1);
        end
      end
    end

    initial begin
      bit ok;
      s_rst_n = 1'b0; s_iv = 1'b0; s_a = '0; s_x = '0; s_sm = 1'b0; s_pend = '0;
      repeat (3) @(posedge clk);
      #1 s_rst_n = 1'b1;
      for (int m = 0; m < 2; m++) begin
        for (int k = 0; k < 1000; k++) begin
          s_a    = NN'($urandom);
          s_x    = NN'($urandom);
          s_sm   = (m == 1);
          s_pend = s_sm ? ({{NN{s_a[NN-1]}}, s_a} * {{NN{s_x[NN-1]}}, s_x})
                        : ({{NN{1'b0}}, s_a} * {{NN{1'b0}}, s_x});
          s_iv   = 1'b1;
          ok     = 1'b0;
          for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = s_ir;
            @(posedge clk);
            #1;
          end
          s_iv = 1'b0;
          if (!ok) chk("sweep_accept_timeout", 32'd0, 32'd1);
        end
      end
      for (int n = 0; n < 100 && s_q.size() != 0; n++) @(posedge clk);
      s_done = 1'b1;
    end
  end

endmodule

// File: doc/seq_mul_radix.md
# seq_mul_radix

Parametrised sequential right-shift multiplier that retires R multiplier bits per clock, in signed (two's complement) or unsigned mode selected per operation. It is the handshaked, multi-bit-per-cycle successor of the K-bit right-shift signed multiplier in the Multiplier_Variations family. It sits between an operand producer and a result consumer, using valid/ready on both sides. It also serves as the reference sequential multiplier for latency/area comparisons across R.

## Interface
- N, 8, operand width; N >= 2
- R, 2, multiplier bits retired per cycle; 1 <= R <= N, N % R == 0 (elaboration error otherwise)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands this cycle
- a  in  N  multiplicand
- x  in  N  multiplier
- signed_mode  in  1  1: a, x two's complement; 0: unsigned
- out_valid  out  1  result held and valid
- out_ready  in  1  consumer takes result
- result  out  2N  product, signed or unsigned per latched mode
- busy  out  1  state != IDLE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready: latch a, x, signed_mode; clear accumulator; cnt=0; go RUN.
- RUN: each cycle takes digit d = x_reg[R-1:0]; x_reg shifts right by R. d unsigned, except the final digit (cnt == N/R-1) in signed mode, which is interpreted as signed R-bit (MSB weight -2^(R-1)).
- Partial product d*a: a sign-extended in signed mode, zero-extended otherwise. Added into accumulator upper part (width N+R+1, signed arithmetic); accumulator then arithmetic-shifts right by R, R shifted-out bits entering result low half from the top.
- After N/R RUN cycles go DONE; result = {acc[N-1:0], low half}, exact product mod 2^(2N).
- DONE: out_valid=1; result, out_valid stable until out_ready. On out_ready: if in_valid also high, accept new operands same cycle and go RUN (in_ready = IDLE || (DONE && out_ready)); else go IDLE.
- in_valid in RUN, or in DONE without out_ready, is ignored (in_ready=0); operands must be held by producer.
- a, x, signed_mode changes after acceptance have no effect.

## Timing
- Reset (asynchronous, any state incl. mid-RUN): state=IDLE, in_ready=1 after reset release, out_valid=0, busy=0, result=0, cnt=0, accumulator and operand registers 0. Any in-flight operation is dropped, no out_valid.
- Latency: out_valid rises exactly N/R clocks after the acceptance edge (N=8, R=2: 4).
- Throughput with out_ready held high and in_valid continuous: one result per N/R+1 clocks.
- result registered; no combinational path from in_* to out_*. in_ready depends combinationally on out_ready in DONE only.
- R=N: single RUN cycle. R=1: N RUN cycles, last digit subtracts a in signed mode.

## Structure
- Package mul_pkg: state_t enum (IDLE, RUN, DONE), helper constant function for cycle count N/R and accumulator width N+R+1.
- Sub-module mul_digit_pp: combinational R-bit digit times N-bit multiplicand, inputs a, d, signed_mode, last_digit; output (N+R+1)-bit signed partial product. Top holds FSM, counter, shift registers, handshake.

## Test plan
- N=8,R=2 signed: a=-128, x=-128 -> result 16'h4000 (16384), out_valid exactly 4 clocks after acceptance.
- Signed: a=127, x=-128 -> -16256 (16'hC080); a=-1, x=1 -> 16'hFFFF. Unsigned: a=255, x=255 -> 65025 (16'hFE01).
- Backpressure: out_ready low 5 cycles in DONE -> result, out_valid stable, in_ready=0; raise out_ready with in_valid high -> new operation accepted that cycle, next result 4 clocks later.
- Reset asserted in 2nd RUN cycle -> outputs immediately reset values, no out_valid; next operation 3*-5 -> -15 correct.
- Parameter sweep (N,R) = (8,1),(8,4),(8,8),(16,4): 1000 random operands per mode vs behavioural a*x; cycle count N/R checked every transaction.
